// File: rtl/spike_encoder_pkg.sv
// Shared definitions for the spike encoder: channel count, widths, LFSR
// tap mask, FSM state encoding and the LFSR helper functions.
package spike_encoder_pkg;

   localparam int unsigned N_CH    = 8;
   localparam int unsigned CHAN_W  = 3;
   localparam int unsigned RATE_W  = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LFSR_W  = 16;

   // Fibonacci taps 16,14,13,11 in a right-shifting register: bits 0,2,3,5
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   typedef logic [RATE_W-1:0] rate_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One Fibonacci step: feedback enters at the MSB, register shifts right
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

   // Per-channel random byte: low byte of the LFSR rotated right by 2*chan
   function automatic rate_t lfsr_slice(input logic [LFSR_W-1:0] s, input int unsigned chan);
      return RATE_W'({s, s} >> (2 * chan));
   endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Spike encoder bus: rate-write handshake, window control and spike output.
//   cfg_valid/cfg_ready/cfg_chan/cfg_rate : rate-table write
//   mode/start/win_len                    : window control (sampled at start)
//   spikes/spike_valid                    : per-step spike vector
//   busy/done                             : window status
interface spike_encoder_if;
   import spike_encoder_pkg::*;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CHAN_W-1:0] cfg_chan;
   rate_t             cfg_rate;
   logic              mode;
   logic              start;
   logic [CNT_W-1:0]  win_len;
   logic [N_CH-1:0]   spikes;
   logic              spike_valid;
   logic              busy;
   logic              done;

   modport master (
      output cfg_valid, cfg_chan, cfg_rate, mode, start, win_len,
      input  cfg_ready, spikes, spike_valid, busy, done
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_rate, mode, start, win_len,
      output cfg_ready, spikes, spike_valid, busy, done
   );

endinterface

// File: rtl/spike_enc_chan.sv
// One encoder channel: stochastic comparator and deterministic accumulator.
//   clear   : zero the accumulator (window start)
//   step    : a timestep fires this cycle
//   mode    : 0 = compare rate against rnd, 1 = accumulate rate
//   rate    : channel rate, spikes per 256 steps
//   rnd     : this channel's random byte for the current step
//   spike_c : combinational spike decision for the current step
module spike_enc_chan
   import spike_encoder_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  step,
   input  logic  mode,
   input  rate_t rate,
   input  rate_t rnd,
   output logic  spike_c
);

   localparam int unsigned SUM_W = RATE_W + 1;

   rate_t            acc_q;
   logic [SUM_W-1:0] sum_c;

   // Carry out of the accumulator is the deterministic spike
   always_comb begin
      sum_c   = {1'b0, acc_q} + SUM_W'(rate);
      spike_c = mode ? sum_c[RATE_W] : (rate > rnd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
      end else if (step && mode) begin
         acc_q <= sum_c[RATE_W-1:0];
      end
   end

endmodule

// File: rtl/spike_encoder.sv
// Rate-to-spike encoder feeding the first LIF layer. Holds the rate table,
// window FSM, step prescaler and shared LFSR; per-channel decisions are made
// by spike_enc_chan instances.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spike_encoder_if slave (config writes, window control, spikes)
module spike_encoder
   import spike_encoder_pkg::*;
#(
   parameter int unsigned       N_CH      = spike_encoder_pkg::N_CH,
   parameter int unsigned       TICK_DIV  = 1,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input logic             clk,
   input logic             rst,
   spike_encoder_if.slave  bus
);

   state_t            state_q;
   rate_t             rate_q [N_CH];
   logic [CNT_W-1:0]  presc_q;
   logic [CNT_W-1:0]  step_q;
   logic [CNT_W-1:0]  win_q;
   logic              mode_q;
   logic [LFSR_W-1:0] lfsr_q;
   logic [N_CH-1:0]   spikes_q;
   logic              spike_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              cfg_ready_q;

   logic              step_fire_c;
   logic              last_step_c;
   logic              start_c;
   logic              cfg_wr_c;
   logic [N_CH-1:0]   chan_spk_c;

   // Step strobe; the 8-bit step count wraps so win_len = 0 means 256 steps
   always_comb begin
      step_fire_c = (state_q == ST_RUN) && (presc_q == CNT_W'(TICK_DIV - 1));
      last_step_c = step_fire_c && ((step_q + CNT_W'(1)) == win_q);
      start_c     = (state_q == ST_IDLE) && bus.start;
      cfg_wr_c    = (state_q == ST_IDLE) && bus.cfg_valid && cfg_ready_q;
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      spike_enc_chan u_chan (
         .clk     (clk),
         .rst     (rst),
         .clear   (start_c),
         .step    (step_fire_c),
         .mode    (mode_q),
         .rate    (rate_q[c]),
         .rnd     (lfsr_slice(lfsr_q, c)),
         .spike_c (chan_spk_c[c])
      );
   end

   // Window FSM, rate table, prescaler, LFSR and registered outputs.
   // The LFSR uses its current value for a step and then advances, in
   // either mode, and is never reloaded except by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rate_q        <= '{default: '0};
         presc_q       <= '0;
         step_q        <= '0;
         win_q         <= '0;
         mode_q        <= 1'b0;
         lfsr_q        <= LFSR_SEED;
         spikes_q      <= '0;
         spike_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cfg_ready_q   <= 1'b0;
      end else begin
         spike_valid_q <= step_fire_c;
         spikes_q      <= step_fire_c ? chan_spk_c : '0;
         busy_q        <= (state_q == ST_RUN);
         done_q        <= (state_q == ST_DONE);

         if (cfg_wr_c) begin
            rate_q[bus.cfg_chan] <= bus.cfg_rate;
         end
         if (step_fire_c) begin
            lfsr_q <= lfsr_next(lfsr_q);
         end

         case (state_q)
            ST_IDLE: begin
               cfg_ready_q <= 1'b1;
               if (bus.start) begin
                  state_q     <= ST_RUN;
                  cfg_ready_q <= 1'b0;
                  presc_q     <= '0;
                  step_q      <= '0;
                  win_q       <= bus.win_len;
                  mode_q      <= bus.mode;
               end
            end
            ST_RUN: begin
               cfg_ready_q <= 1'b0;
               if (step_fire_c) begin
                  presc_q <= '0;
                  step_q  <= step_q + CNT_W'(1);
                  if (last_step_c) begin
                     state_q <= ST_DONE;
                  end
               end else begin
                  presc_q <= presc_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               cfg_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_IDLE;
               cfg_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cfg_ready   = cfg_ready_q;
   assign bus.spikes      = spikes_q;
   assign bus.spike_valid = spike_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: stimulus pushes expected spike vectors,
// a negedge monitor pops and compares whenever spike_valid is high.
module tb_spike_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spike_encoder_if bus ();
   spike_encoder_if bus4 ();

   spike_encoder #(.N_CH(8), .TICK_DIV(1), .LFSR_SEED(16'hACE1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   spike_encoder #(.N_CH(8), .TICK_DIV(4), .LFSR_SEED(16'hACE1)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_sv_cyc = -10;
   int sv_cnt = 0;
   int done_cnt = 0;
   int ch_cnt [8];

   logic [7:0]  exp_q [$];
   logic [7:0]  m_rate [8];
   logic [7:0]  m_acc [8];
   logic [15:0] m_lfsr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one timestep over all channels, then LFSR advance
   task automatic model_step(input bit md, output logic [7:0] v);
      logic [8:0]  sum;
      logic [31:0] dbl;
      logic [7:0]  r;
      logic        fb;
      v = '0;
      for (int c = 0; c < 8; c++) begin
         if (md) begin
            sum      = {1'b0, m_acc[c]} + {1'b0, m_rate[c]};
            m_acc[c] = sum[7:0];
            v[c]     = sum[8];
         end else begin
            dbl  = {m_lfsr, m_lfsr} >> (2 * c);
            r    = dbl[7:0];
            v[c] = (m_rate[c] > r);
         end
      end
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
   endtask

   task automatic model_reset();
      for (int c = 0; c < 8; c++) begin
         m_rate[c] = '0;
         m_acc[c]  = '0;
      end
      m_lfsr = 16'hACE1;
   endtask

   task automatic push_model(input bit md, input int n);
      logic [7:0] v;
      for (int c = 0; c < 8; c++) m_acc[c] = '0;
      for (int i = 0; i < n; i++) begin
         model_step(md, v);
         exp_q.push_back(v);
      end
   endtask

   task automatic cfg_write(input int ch, input int rt);
      @(negedge clk);
      check("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_chan  = 3'(ch);
      bus.cfg_rate  = 8'(rt);
      @(posedge clk);
      #1 bus.cfg_valid = 1'b0;
      m_rate[ch] = 8'(rt);
   endtask

   task automatic kick(input bit md, input int win, input bit wr, input int ch, input int rt);
      @(negedge clk);
      bus.mode      = md;
      bus.win_len   = 8'(win);
      bus.start     = 1'b1;
      bus.cfg_valid = wr;
      bus.cfg_chan  = 3'(ch);
      bus.cfg_rate  = 8'(rt);
      sv_cnt        = 0;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < n * 4 + 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check({name, "_done"}, 32'(seen), 32'd1);
      check({name, "_steps"}, 32'(sv_cnt), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: scoreboard pop on spike_valid, quiet spikes otherwise, done gap
   always @(negedge clk) begin
      cyc++;
      if (bus.spike_valid === 1'b1) begin
         sv_cnt++;
         last_sv_cyc = cyc;
         for (int c = 0; c < 8; c++) ch_cnt[c] += int'(bus.spikes[c]);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got spikes 0x%0h, expected no output", bus.spikes);
         end else begin
            check("sb_spikes", 32'(bus.spikes), 32'(exp_q.pop_front()));
         end
      end else begin
         check("spikes_quiet", 32'(bus.spikes), 32'd0);
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         check("done_gap", 32'(cyc - last_sv_cyc), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      int sv_n, busy_n, prev, dc;
      bit seen_done;

      rst = 1'b1;
      bus.cfg_valid = 0; bus.cfg_chan = 0; bus.cfg_rate = 0;
      bus.mode = 0; bus.start = 0; bus.win_len = 0;
      bus4.cfg_valid = 0; bus4.cfg_chan = 0; bus4.cfg_rate = 0;
      bus4.mode = 0; bus4.start = 0; bus4.win_len = 0;
      model_reset();
      for (int c = 0; c < 8; c++) ch_cnt[c] = 0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);

      // TICK_DIV=4, 3 steps: valid spaced 4 apart, busy for 12 cycles
      @(negedge clk);
      bus4.cfg_valid = 1'b1; bus4.cfg_chan = 3'd0; bus4.cfg_rate = 8'd128;
      bus4.mode = 1'b1; bus4.win_len = 8'd3; bus4.start = 1'b1;
      @(posedge clk);
      #1 bus4.start = 1'b0; bus4.cfg_valid = 1'b0;
      sv_n = 0; busy_n = 0; prev = 0; seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus4.busy === 1'b1) busy_n++;
         if (bus4.spike_valid === 1'b1) begin
            if (sv_n > 0) check("td4_gap", 32'(i - prev), 32'd4);
            check("td4_spikes", 32'(bus4.spikes), (sv_n == 1) ? 32'd1 : 32'd0);
            prev = i;
            sv_n++;
         end
         if (bus4.done === 1'b1) seen_done = 1'b1;
      end
      check("td4_sv_count", 32'(sv_n), 32'd3);
      check("td4_busy_cycles", 32'(busy_n), 32'd12);
      check("td4_done", 32'(seen_done), 32'd1);

      // Rate 128 written in the start cycle: 0,1,0,1,... for 8 steps
      m_rate[0] = 8'd128;
      for (int c = 0; c < 8; c++) m_acc[c] = '0;
      for (int i = 0; i < 8; i++) begin
         model_step(1'b1, v);
         exp_q.push_back((i % 2 == 1) ? 8'h01 : 8'h00);
      end
      kick(1'b1, 8, 1'b1, 0, 128);
      wait_done(8, "det128");

      // 256-step deterministic window: counts 0,1,64,255
      cfg_write(0, 0);
      cfg_write(1, 1);
      cfg_write(2, 64);
      cfg_write(3, 255);
      push_model(1'b1, 256);
      for (int c = 0; c < 8; c++) ch_cnt[c] = 0;
      kick(1'b1, 0, 1'b0, 0, 0);
      wait_done(256, "det256");
      check("cnt_ch0", 32'(ch_cnt[0]), 32'd0);
      check("cnt_ch1", 32'(ch_cnt[1]), 32'd1);
      check("cnt_ch2", 32'(ch_cnt[2]), 32'd64);
      check("cnt_ch3", 32'(ch_cnt[3]), 32'd255);
      for (int c = 4; c < 8; c++) check("cnt_zero_ch", 32'(ch_cnt[c]), 32'd0);

      // Stochastic from seed ACE1, rate[3]=255, 16 steps
      do_reset();
      check("reset_sb_empty", 32'(exp_q.size()), 32'd0);
      cfg_write(3, 255);
      push_model(1'b0, 16);
      kick(1'b0, 16, 1'b0, 0, 0);
      wait_done(16, "stoch16");

      // cfg writes and start are ignored while running
      cfg_write(0, 128);
      push_model(1'b1, 10);
      kick(1'b1, 10, 1'b0, 0, 0);
      @(negedge clk);
      check("cfg_ready_run", 32'(bus.cfg_ready), 32'd0);
      bus.cfg_valid = 1'b1; bus.cfg_chan = 3'd0; bus.cfg_rate = 8'd7;
      bus.start = 1'b1; bus.win_len = 8'd2;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.cfg_valid = 1'b0;
      wait_done(10, "run_ignore");
      push_model(1'b1, 4);
      kick(1'b1, 4, 1'b0, 0, 0);
      wait_done(4, "rate_kept");

      // Reset at step 5 of a 10-step window aborts without done
      for (int i = 0; i < 4; i++) begin
         model_step(1'b0, v);
         exp_q.push_back(v);
      end
      kick(1'b0, 10, 1'b0, 0, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_spike_valid", 32'(bus.spike_valid), 32'd0);
      check("abort_spikes", 32'(bus.spikes), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      dc = done_cnt;
      repeat (20) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'(dc));
      check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

      // LFSR back at ACE1 after the abort
      model_reset();
      cfg_write(3, 255);
      cfg_write(5, 200);
      cfg_write(0, 100);
      push_model(1'b0, 16);
      kick(1'b0, 16, 1'b0, 0, 0);
      wait_done(16, "seed_reload");

      repeat (3) @(negedge clk);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter N_CH, default 8: number of encoded channels, one per first-layer LIF neuron.
REQ-002 Parameter TICK_DIV, default 1: clock cycles per encoding timestep (1..255).
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value, non-zero.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_valid  input  1  rate-write request.
REQ-007 cfg_ready  output  1  rate-write can be accepted.
REQ-008 cfg_chan  input  3  channel index of the rate write.
REQ-009 cfg_rate  input  8  channel rate; spikes per 256 steps.
REQ-010 mode  input  1  0 = stochastic (LFSR), 1 = deterministic (accumulator); sampled at start.
REQ-011 start  input  1  one-cycle pulse that begins an encoding window.
REQ-012 win_len  input  8  steps per window; sampled at start; 0 means 256.
REQ-013 spikes  output  N_CH  per-channel spike bits; these drive the LIF network current inputs.
REQ-014 spike_valid  output  1  high on the cycle spikes reflects a new timestep.
REQ-015 busy  output  1  high while a window is running.
REQ-016 done  output  1  one-cycle pulse after the last step of a window.

Function
REQ-017 FSM states: IDLE, RUN, DONE. Transitions: IDLE->RUN on start; RUN->DONE after win_len steps; DONE->IDLE unconditionally after one cycle.
REQ-018 cfg_ready is 1 in IDLE only; a write occurs when cfg_valid&cfg_ready, and rate[cfg_chan] takes cfg_rate on that edge.
REQ-019 A start pulse outside IDLE is ignored; start and a cfg write in the same IDLE cycle both take effect, and the new rate applies from step 1.
REQ-020 On the start edge: step counter <- 0, prescaler <- 0, and accumulators <- 0.
REQ-021 Step generation: a prescaler counts 0..TICK_DIV-1 in RUN, and a step fires when it equals TICK_DIV-1; with TICK_DIV=1, a step fires every RUN cycle.
REQ-022 The first step fires on the first RUN cycle whose prescaler equals TICK_DIV-1; outputs are registered, so spikes and spike_valid appear one cycle after the step fires.
REQ-023 Stochastic mode: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per step; channel c uses r_c = bits[7:0] of the LFSR rotated right by 2*c; spike_c = (rate[c] > r_c).
REQ-024 Deterministic mode: per step, a 9-bit sum = {0,acc[c]} + rate[c]; acc[c] <- sum[7:0]; spike_c = sum[8].
REQ-025 rate 0 never spikes in either mode; rate 255 in deterministic mode spikes 255 times per 256 steps.
REQ-026 spikes is 0 and spike_valid is 0 on every cycle without a step output.
REQ-027 busy = 1 in RUN; done = 1 in DONE only.
REQ-028 The step counter is 8 bits and wraps; a window of win_len=0 ends after 256 steps.
REQ-029 The LFSR is not reloaded at start, and it continues across windows.

Reset
REQ-030 When rst=1 at an edge: FSM <- IDLE; all rates, accumulators, counters and the prescaler <- 0; LFSR <- LFSR_SEED.
REQ-031 Reset values of the outputs: spikes=0, spike_valid=0, busy=0, done=0, cfg_ready=0 during reset and 1 on the first cycle after reset.
REQ-032 Reset asserted mid-window aborts the window without a done pulse.

Structure
REQ-033 A shared package holds N_CH, the LFSR width, the tap mask, the state enumeration, and the rate width.
REQ-034 The per-channel comparator and accumulator form one sub-module, spike_enc_chan, instantiated N_CH times; the FSM, prescaler and LFSR live in the top.

Verification
REQ-035 Deterministic mode, rate[0]=128, win_len=8, TICK_DIV=1 -> spikes[0] pattern 0,1,0,1,0,1,0,1; 8 spike_valid pulses; done one cycle after the last.
REQ-036 Deterministic mode, rates {0,1,64,255,...}, win_len=0 -> per-channel counts over 256 steps of 0, 1, 64, 255.
REQ-037 Stochastic mode, seed ACE1, rate[3]=255, 16 steps -> spikes[3] matches a reference-model LFSR sequence bit-exactly; rate 0 channels stay 0.
REQ-038 TICK_DIV=4, win_len=3 -> spike_valid high on exactly 3 cycles, spaced 4 cycles apart; busy high for 12 cycles.
REQ-039 cfg_valid held high during RUN -> no rate change until IDLE; a start pulse during RUN is ignored and the window length is unchanged.
REQ-040 rst asserted at step 5 of a 10-step window -> next cycle busy=0, spikes=0, no done pulse, and the LFSR equals ACE1.
